// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
// Shared definitions for the serial-in/parallel-out deserializer.
//   state_t   : receive FSM states (PARITY only reachable when SIPO_PARITY_EN
//               is defined)
//   MSB_FIRST : value of the msb_first input that selects MSB-first ordering
// -----------------------------------------------------------------------------
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_deser_if.sv
// -----------------------------------------------------------------------------
// sipo_deser_if
// Bundles the serial input side and the ready/valid word output side of the
// deserializer.
//   master : serial source + word consumer (drives ser_*, start, msb_first,
//            clr_ovr, dout_ready; observes dout, dout_valid, dout_err,
//            overrun, frame_abort)
//   slave  : the deserializer itself
// Parameter N is the word width.
// -----------------------------------------------------------------------------
interface sipo_deser_if #(
  parameter int N = 4
);

  logic         ser_in;
  logic         ser_valid;
  logic         start;
  logic         msb_first;
  logic         clr_ovr;
  logic [N-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_err;
  logic         overrun;
  logic         frame_abort;

  modport master (
    output ser_in, ser_valid, start, msb_first, clr_ovr, dout_ready,
    input  dout, dout_valid, dout_err, overrun, frame_abort
  );

  modport slave (
    input  ser_in, ser_valid, start, msb_first, clr_ovr, dout_ready,
    output dout, dout_valid, dout_err, overrun, frame_abort
  );

endinterface

// File: rtl/sipo_bit_cnt.sv
// -----------------------------------------------------------------------------
// sipo_bit_cnt
// Frame bit counter for the deserializer.
//   clk, reset_b : clock, asynchronous active-low reset
//   i_load       : start of frame, count becomes 1 (bit 0 already taken)
//   i_inc        : one more data bit accepted
//   i_clr        : frame finished, count returns to 0
//   o_term       : the next accepted data bit is the last one (count == N-1)
// -----------------------------------------------------------------------------
module sipo_bit_cnt #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic clk,
  input  logic reset_b,
  input  logic i_load,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_term
);

  logic [CW-1:0] r_cnt;

  // NOTE: clocked state uses non-blocking assignments so every register in
  // the design samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(1);
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_term = (r_cnt == CW'(N - 1));

endmodule

// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser
// Serial-in/parallel-out deserializer. Rebuilds N-bit words shifted in
// MSB-first or LSB-first (chosen per frame on bit 0) and double-buffers each
// completed word into a ready/valid output register.
//   clk     : clock, all state changes on the rising edge
//   reset_b : asynchronous active-low reset
//   bus     : sipo_deser_if.slave (serial input, word output, status flags)
// Build option: define SIPO_PARITY_EN to expect an even-parity bit after the
// N data bits and report mismatches on dout_err; otherwise dout_err is 0.
// -----------------------------------------------------------------------------
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_b,
  sipo_deser_if.slave  bus
);

  state_t       r_state;
  logic [N-1:0] r_sr;
  logic         r_msb;
  logic [N-1:0] r_dout;
  logic         r_dout_valid;
  logic         r_dout_err;
  logic         r_overrun;
  logic         r_frame_abort;

  logic         w_new_frame;
  logic         w_abort;
  logic         w_data_bit;
  logic         w_term;
  logic         w_order;
  logic [N-1:0] w_sr_base;
  logic [N-1:0] w_sr_next;
  logic         w_xfer;
  logic [N-1:0] w_xfer_word;
  logic         w_xfer_err;

  // A qualified start always begins a new frame, even in the middle of one.
  assign w_new_frame = bus.ser_valid && bus.start;
  assign w_abort     = w_new_frame && (r_state != IDLE);
  assign w_data_bit  = bus.ser_valid && !bus.start && (r_state == SHIFT);

  // Bit 0 is shifted into an empty register using the order being latched,
  // so one shift expression serves both the first and later bits.
  assign w_order   = w_new_frame ? bus.msb_first : r_msb;
  assign w_sr_base = w_new_frame ? '0 : r_sr;
  assign w_sr_next = (w_order == MSB_FIRST) ? {w_sr_base[N-2:0], bus.ser_in}
                                            : {bus.ser_in, w_sr_base[N-1:1]};

`ifdef SIPO_PARITY_EN
  // The parity bit completes the frame; the word is already in r_sr.
  assign w_xfer      = bus.ser_valid && !bus.start && (r_state == PARITY);
  assign w_xfer_word = r_sr;
  assign w_xfer_err  = ^{r_sr, bus.ser_in};
`else
  assign w_xfer      = w_data_bit && w_term;
  assign w_xfer_word = w_sr_next;
  assign w_xfer_err  = 1'b0;
`endif

  sipo_bit_cnt #(.N(N)) u_bit_cnt (
    .clk     (clk),
    .reset_b (reset_b),
    .i_load  (w_new_frame),
    .i_inc   (w_data_bit),
    .i_clr   (w_xfer),
    .o_term  (w_term)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state       <= IDLE;
      r_sr          <= '0;
      r_msb         <= 1'b0;
      r_dout        <= '0;
      r_dout_valid  <= 1'b0;
      r_dout_err    <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_frame_abort <= w_abort;

      // Receive FSM
      if (w_new_frame) begin
        r_state <= SHIFT;
        r_msb   <= bus.msb_first;
        r_sr    <= w_sr_next;
      end else if (w_data_bit) begin
        r_sr <= w_sr_next;
        if (w_term) begin
`ifdef SIPO_PARITY_EN
          r_state <= PARITY;
`else
          r_state <= IDLE;
`endif
        end
      end else if (w_xfer) begin
        r_state <= IDLE;
      end

      // Output register: a pending word accepted this cycle frees the slot.
      if (w_xfer) begin
        if (!r_dout_valid || bus.dout_ready) begin
          r_dout       <= w_xfer_word;
          r_dout_err   <= w_xfer_err;
          r_dout_valid <= 1'b1;
        end
      end else if (r_dout_valid && bus.dout_ready) begin
        r_dout_valid <= 1'b0;
      end

      // Setting a dropped word wins over a same-cycle clear request.
      if (w_xfer && r_dout_valid && !bus.dout_ready) begin
        r_overrun <= 1'b1;
      end else if (bus.clr_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.dout        = r_dout;
  assign bus.dout_valid  = r_dout_valid;
  assign bus.dout_err    = r_dout_err;
  assign bus.overrun     = r_overrun;
  assign bus.frame_abort = r_frame_abort;

endmodule

// File: tb/tb_sipo_deser.sv
// -----------------------------------------------------------------------------
// tb_sipo_deser
// Self-checking bench for sipo_deser with N=8. A frame-level reference model
// (bit queue per frame, word assembled arithmetically) predicts every output
// after each clock edge; directed scenarios add constant expectations.
// -----------------------------------------------------------------------------
module tb_sipo_deser;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  sipo_deser_if #(.N(N)) bus ();

  sipo_deser #(.N(N)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  bit         m_in_frame;
  bit         m_par_phase;
  bit         m_order;
  bit         m_bits[$];
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_err;
  logic       m_ovr;
  logic       m_abort;

  function automatic logic [7:0] build_word();
    logic [7:0] w = '0;
    for (int i = 0; i < N; i++) begin
      if (m_order) w[N-1-i] = m_bits[i];
      else         w[i]     = m_bits[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    m_in_frame = 0; m_par_phase = 0; m_order = 0; m_bits.delete();
    m_dout = '0; m_valid = 0; m_err = 0; m_ovr = 0; m_abort = 0;
  endtask

  task automatic model_edge(input logic sv, si, st, msb, rdy, clr);
    logic       xfer = 0;
    logic [7:0] word = '0;
    logic       err = 0;
    logic       set_ovr = 0;
    m_abort = 0;
    if (sv && st) begin
      m_abort = m_in_frame;
      m_in_frame = 1; m_par_phase = 0; m_order = msb;
      m_bits.delete(); m_bits.push_back(si);
    end else if (sv && m_in_frame) begin
      if (!m_par_phase) begin
        m_bits.push_back(si);
        if (m_bits.size() == N) begin
`ifdef SIPO_PARITY_EN
          m_par_phase = 1;
`else
          xfer = 1; word = build_word(); err = 0; m_in_frame = 0;
`endif
        end
      end else begin
        word = build_word();
        xfer = 1; err = (($countones(word) + int'(si)) % 2) != 0;
        m_in_frame = 0; m_par_phase = 0;
      end
    end
    if (xfer) begin
      if (!m_valid || rdy) begin
        m_dout = word; m_err = err; m_valid = 1;
      end else begin
        set_ovr = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (set_ovr)  m_ovr = 1;
    else if (clr) m_ovr = 0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("dout",        32'(bus.dout),        32'(m_dout));
    check("dout_valid",  32'(bus.dout_valid),  32'(m_valid));
    check("dout_err",    32'(bus.dout_err),    32'(m_err));
    check("overrun",     32'(bus.overrun),     32'(m_ovr));
    check("frame_abort", 32'(bus.frame_abort), 32'(m_abort));
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic step(input logic sv, si, st, msb, rdy, clr);
    bus.ser_valid = sv; bus.ser_in = si; bus.start = st;
    bus.msb_first = msb; bus.dout_ready = rdy; bus.clr_ovr = clr;
    @(posedge clk);
    model_edge(sv, si, st, msb, rdy, clr);
    #1;
    compare_all();
  endtask

  task automatic idle(input logic rdy, input logic clr);
    step(0, 0, 0, 0, rdy, clr);
  endtask

  // seq[7] is sent first. With parity enabled a parity bit follows
  // (correct even parity unless par_bad). rdy_last applies to the final bit.
  task automatic send_frame(input logic [7:0] seq, input logic msb,
                            input logic rdy_mid, input logic rdy_last,
                            input logic par_bad);
    for (int i = 0; i < N; i++) begin
`ifdef SIPO_PARITY_EN
      step(1, seq[N-1-i], i == 0, msb, rdy_mid, 0);
`else
      step(1, seq[N-1-i], i == 0, msb, (i == N-1) ? rdy_last : rdy_mid, 0);
`endif
    end
`ifdef SIPO_PARITY_EN
    step(1, (^seq) ^ par_bad, 0, msb, rdy_last, 0);
`else
    if (par_bad) $display("note: parity bit not used in this build");
`endif
  endtask

  task automatic do_reset();
    #2 reset_b = 1'b0;
    #1;
    check("rst_dout",        32'(bus.dout),        32'h0);
    check("rst_dout_valid",  32'(bus.dout_valid),  32'h0);
    check("rst_dout_err",    32'(bus.dout_err),    32'h0);
    check("rst_overrun",     32'(bus.overrun),     32'h0);
    check("rst_frame_abort", 32'(bus.frame_abort), 32'h0);
    model_reset();
    @(posedge clk);
    #1 reset_b = 1'b1;
  endtask

  initial begin
    bus.ser_valid = 0; bus.ser_in = 0; bus.start = 0;
    bus.msb_first = 0; bus.dout_ready = 0; bus.clr_ovr = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset_b = 1'b1;
    idle(0, 0);

    // MSB-first 1,0,1,0,0,1,0,1 -> A5
    send_frame(8'b1010_0101, 1, 0, 0, 0);
    check("msb_word",  32'(bus.dout),       32'hA5);
    check("msb_valid", 32'(bus.dout_valid), 32'h1);
    idle(1, 0);
    check("drained", 32'(bus.dout_valid), 32'h0);

    // LSB-first 1,1,0,0,0,0,0,0 -> 03
    send_frame(8'b1100_0000, 0, 0, 0, 0);
    check("lsb_word", 32'(bus.dout), 32'h03);

    // Back-to-back with ready low: first word held (03), new ones dropped
    send_frame(8'h3C, 1, 0, 0, 0);
    send_frame(8'h81, 0, 0, 0, 0);
    check("ovr_held",  32'(bus.dout),    32'h03);
    check("ovr_set",   32'(bus.overrun), 32'h1);
    idle(0, 1);
    check("ovr_clear", 32'(bus.overrun), 32'h0);

    // Completion with dout_ready high in the same cycle
    send_frame(8'h5A, 1, 0, 1, 0);
    check("same_cyc_word", 32'(bus.dout),    32'h5A);
    check("same_cyc_ovr",  32'(bus.overrun), 32'h0);
    idle(1, 0);

    // Abort at bit 5, then a clean frame whose first bit is the abort start
    for (int i = 0; i < 5; i++) step(1, 1'(i & 1), i == 0, 1, 0, 0);
    send_frame(8'hC3, 1, 0, 0, 0);
    check("abort_word", 32'(bus.dout), 32'hC3);
    idle(1, 0);
    step(1, 1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    check("abort_pulse", 32'(bus.frame_abort), 32'h1);
    idle(0, 0);
    check("abort_clear", 32'(bus.frame_abort), 32'h0);

`ifdef SIPO_PARITY_EN
    // Word 01 (MSB-first): parity bit 0 -> error, parity bit 1 -> ok
    send_frame(8'h01, 1, 1, 1, 1);
    check("par_err_word", 32'(bus.dout),     32'h01);
    check("par_err",      32'(bus.dout_err), 32'h1);
    send_frame(8'h01, 1, 1, 1, 0);
    check("par_ok",       32'(bus.dout_err), 32'h0);
    idle(1, 0);
`endif

    // Reset mid-frame, then a clean frame
    send_frame(8'h77, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, i == 0, 1, 0, 0);
    do_reset();
    send_frame(8'h96, 0, 0, 0, 0);
    check("post_rst_word", 32'(bus.dout), 32'h69);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 9) < 7,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in/parallel-out deserializer with a framed bit-strobe input and a ready/valid parallel output. It is the receive end of the shift-register serial link: it rebuilds n-bit words shifted out MSB-first or LSB-first by the transmitting shift register. Completed words are double-buffered into an output register so the next frame can shift in while the consumer drains the previous word. It sits between the serial pin-side logic and word-oriented datapath consumers.

## Interface
- n, default 4: word width; legal range n ≥ 2.
- clk  input  1  clock; all state changes on the rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  bit strobe; ser_in is sampled only when high.
- start  input  1  frame marker; qualified by ser_valid, it marks bit 0 of a frame.
- msb_first  input  1  bit order; sampled only on the frame's bit 0.
- clr_ovr  input  1  clears the overrun flag.
- dout  output  n  received word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid and dout_ready are both high.
- dout_err  output  1  parity error for the word on dout; 0 when parity is compiled out.
- overrun  output  1  sticky flag: a completed word was dropped.
- frame_abort  output  1  one-cycle pulse: a partial frame was discarded.

## Operation
- States: IDLE, SHIFT, PARITY (present only with SIPO_PARITY_EN).
- IDLE:
  - ser_valid&start captures bit 0 into the shift register, latches msb_first, sets bit count to 1, and goes to SHIFT.
  - ser_valid without start is ignored.
- SHIFT, each ser_valid:
  - msb_first=1: sr ← {sr[n-2:0], ser_in}.
  - msb_first=0: sr ← {ser_in, sr[n-1:1]}.
  - The bit count increments.
- Completion on the n-th data bit: go to PARITY if enabled; otherwise transfer the word and return to IDLE.
- PARITY: the next ser_valid bit is the even-parity bit; transfer the word, set dout_err = ^{word, parity_bit}, return to IDLE.
- Transfer rules:
  - dout_valid=0, or dout_valid=1 with dout_ready=1 in the same cycle: dout and dout_err load and dout_valid is 1.
  - dout_valid=1 with dout_ready=0: the new word is dropped, dout is held, overrun is set.
- Handshake with no transfer: dout_valid clears after dout_ready&dout_valid.
- start&ser_valid while in SHIFT or PARITY:
  - The partial frame is discarded and frame_abort pulses.
  - The bit is taken as bit 0 of a new frame (count=1, msb_first re-latched).
- overrun: set has priority over clr_ovr in the same cycle. It clears only on clr_ovr or reset.
- Reset values: dout=0, dout_valid=0, dout_err=0, overrun=0, frame_abort=0, state IDLE, count 0, shift register 0.
- An asynchronous reset mid-frame discards the frame and any held word.

## Timing
- Transfer latency is 1 cycle: the last bit (data bit n, or the parity bit) is sampled at edge k, and dout/dout_valid are updated at edge k.
- Back-to-back frames with ser_valid held high every cycle are sustained: bit 0 of the next frame may arrive at the cycle immediately after the last bit.
- A frame is n cycles minimum (n+1 with parity).
- ser_valid may gap arbitrarily mid-frame; the state is held.
- frame_abort is high for exactly the one cycle following the abort edge.
- dout is stable while dout_valid=1 and not yet accepted.

## Configuration
- SIPO_PARITY_EN defined: the PARITY state exists, each frame is n+1 bits, and dout_err reports even-parity mismatch.
- SIPO_PARITY_EN undefined: no PARITY state, frames are n bits, and dout_err is tied to 0. The port list is identical in both builds.

## Structure
- Shared package sipo_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - the constant encoding for the bit-order select (MSB_FIRST=1).
- One sub-module is natural: sipo_bit_cnt, a $clog2(n+1)-bit frame counter with load-to-1, increment, and terminal flag.
- The shift register, output register, FSM and flags stay in sipo_deser.

## Test plan
All scenarios use n=8.
- MSB-first frame with bits 1,0,1,0,0,1,0,1 sent, no parity → dout=8'hA5, dout_valid=1 at the edge sampling the last bit.
- LSB-first frame with the same bit sequence → dout=8'hA5 reversed = 8'hA5 bit-swapped = 8'hA5→8'hA5 is palindromic, so use bits 1,1,0,0,0,0,0,0 → dout=8'h03.
- Two back-to-back frames with dout_ready held low → first word held, overrun=1. Then clr_ovr=1 → overrun=0 next cycle.
- Completion with dout_ready=1 in the same cycle → new word loaded, overrun stays 0.
- start&ser_valid at bit 5 of a frame → one-cycle frame_abort pulse, then a following clean frame delivers the correct word.
- With SIPO_PARITY_EN: word 8'h01 with parity bit 0 → dout_err=1; the same word with parity bit 1 → dout_err=0.
- reset_b pulsed low mid-frame → all outputs 0 immediately, and the next frame is received correctly.
